// File: rtl/dc_bsp_pkg.sv
// Shared board-support definitions for the I/O pipe egress path:
// channel count, shim beat width, channel tag width and the mux FSM states.
package dc_bsp_pkg;

   localparam int IO_PIPES_NUM_CHAN      = 16;
   localparam int SHIM_AVST_DATA_WIDTH   = 64;
   localparam int IO_PIPES_TX_CHAN_WIDTH = $clog2(IO_PIPES_NUM_CHAN);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } io_pipes_tx_state_e;

endpackage : dc_bsp_pkg

// File: rtl/io_pipes_tx_skid.sv
// Generic 2-entry valid/ready skid buffer. in_ready comes only from the
// occupancy register, so there is no combinational path from out_ready back
// to in_ready. Payload reads as zero while the buffer is empty.
module io_pipes_tx_skid
   import dc_bsp_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_payload,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_payload
);

   logic [W-1:0] mem_reg [2];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   logic [1:0]   count_reg;
   logic         push;
   logic         pop;

   assign in_ready    = (count_reg != 2'd2);
   assign out_valid   = (count_reg != 2'd0);
   assign push        = in_valid & in_ready;
   assign pop         = out_valid & out_ready;
   assign out_payload = out_valid ? mem_reg[rd_ptr_reg] : '0;

   // Occupancy and pointers; reset discards anything buffered.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage entries carry no reset; the empty flag masks stale contents.
   always_ff @(posedge clk) begin
      if (push) mem_reg[wr_ptr_reg] <= in_payload;
   end

endmodule : io_pipes_tx_skid

// File: rtl/io_pipes_tx_mux.sv
// Kernel-to-host egress mux: merges NUM_CHAN Avalon-ST pipe channels into one
// channel-tagged stream with packet-atomic round-robin arbitration.
// Optional macro IO_PIPES_TX_OUTREG_EN registers the outputs through a
// 2-entry skid buffer (1-cycle latency); otherwise the path is combinational.
module io_pipes_tx_mux
   import dc_bsp_pkg::*;
#(
   parameter int NUM_CHAN   = IO_PIPES_NUM_CHAN,
   parameter int DATA_WIDTH = SHIM_AVST_DATA_WIDTH,
   parameter int CHAN_WIDTH = $clog2(NUM_CHAN)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CHAN-1:0]            k_valid,
   input  logic [NUM_CHAN*DATA_WIDTH-1:0] k_data,
   input  logic [NUM_CHAN-1:0]            k_sop,
   input  logic [NUM_CHAN-1:0]            k_eop,
   output logic [NUM_CHAN-1:0]            k_ready,
   output logic                           tx_valid,
   output logic [DATA_WIDTH-1:0]          tx_data,
   output logic [CHAN_WIDTH-1:0]          tx_channel,
   output logic                           tx_sop,
   output logic                           tx_eop,
   input  logic                           tx_ready
);

   // First requester strictly after ptr, wrapping; MSB flags "found".
   function automatic logic [CHAN_WIDTH:0] rr_first(input logic [NUM_CHAN-1:0] req,
                                                    input logic [CHAN_WIDTH-1:0] ptr);
      logic [CHAN_WIDTH:0] res;
      int                  idx;
      res = '0;
      for (int k = NUM_CHAN; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_CHAN;
         if (req[idx]) res = {1'b1, idx[CHAN_WIDTH-1:0]};
      end
      return res;
   endfunction

   io_pipes_tx_state_e    state_reg;
   logic [CHAN_WIDTH-1:0] rr_ptr_reg;
   logic [CHAN_WIDTH-1:0] lock_chan_reg;
   logic                  hold_reg;
   logic [CHAN_WIDTH-1:0] hold_chan_reg;

   logic [CHAN_WIDTH:0]   rr_res;
   logic [CHAN_WIDTH-1:0] sel_chan;
   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_sop;
   logic                  sel_eop;
   logic                  accept;
   logic                  fire;

   assign rr_res = rr_first(k_valid, rr_ptr_reg);

   // Selected source: locked channel, else a stalled grant frozen until
   // accepted, else the fresh round-robin winner.
   always_comb begin
      sel_chan  = rr_res[CHAN_WIDTH-1:0];
      sel_valid = rr_res[CHAN_WIDTH];
      if (state_reg == LOCKED) begin
         sel_chan  = lock_chan_reg;
         sel_valid = k_valid[lock_chan_reg];
      end else if (hold_reg) begin
         sel_chan  = hold_chan_reg;
         sel_valid = k_valid[hold_chan_reg];
      end
      if (reset) sel_valid = 1'b0;
   end

   assign sel_data = k_data[int'(sel_chan)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_sop  = k_sop[sel_chan];
   assign sel_eop  = k_eop[sel_chan];
   assign fire     = sel_valid & accept;

   // Ready is one-hot on the selected channel, or all zero.
   generate
      for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_ready
         assign k_ready[gi] = sel_valid & accept & (sel_chan == CHAN_WIDTH'(gi));
      end
   endgenerate

`ifdef IO_PIPES_TX_OUTREG_EN
   localparam int PW = 2 + CHAN_WIDTH + DATA_WIDTH;
   logic [PW-1:0] out_payload;

   io_pipes_tx_skid #(
      .W (PW)
   ) u_skid (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (sel_valid),
      .in_ready    (accept),
      .in_payload  ({sel_sop, sel_eop, sel_chan, sel_data}),
      .out_valid   (tx_valid),
      .out_ready   (tx_ready),
      .out_payload (out_payload)
   );

   assign {tx_sop, tx_eop, tx_channel, tx_data} = out_payload;
`else
   assign accept     = tx_ready;
   assign tx_valid   = sel_valid;
   assign tx_data    = sel_valid ? sel_data : '0;
   assign tx_channel = sel_valid ? sel_chan : '0;
   assign tx_sop     = sel_valid & sel_sop;
   assign tx_eop     = sel_valid & sel_eop;
`endif

   // Arbitration FSM: lock on a non-final beat, release on eop and resume the
   // search just after the channel that finished.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= CHAN_WIDTH'(NUM_CHAN - 1);
         lock_chan_reg <= '0;
         hold_reg      <= 1'b0;
         hold_chan_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (fire) begin
                  hold_reg <= 1'b0;
                  if (sel_eop) begin
                     rr_ptr_reg <= sel_chan;
                  end else begin
                     state_reg     <= LOCKED;
                     lock_chan_reg <= sel_chan;
                  end
               end else if (sel_valid) begin
                  hold_reg      <= 1'b1;
                  hold_chan_reg <= sel_chan;
               end else begin
                  hold_reg <= 1'b0;
               end
            end
            LOCKED: begin
               if (fire && sel_eop) begin
                  state_reg  <= IDLE;
                  rr_ptr_reg <= lock_chan_reg;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule : io_pipes_tx_mux
